// File: rtl/nios_system_pio_pkg.sv
`default_nettype none
// ============================================================================
// Package     : nios_system_pio_pkg
// Description : Shared constants for the pulse-capable PIO slave: Avalon-MM
//               word addresses of each register, the STATUS busy bit index,
//               and the decoded-write bundle used by the register file.
// Revision    : 1.0  initial release
// ============================================================================
package nios_system_pio_pkg;

  // Register word addresses
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_SET    = 3'd1;
  localparam logic [2:0] ADDR_CLR    = 3'd2;
  localparam logic [2:0] ADDR_PULSE  = 3'd3;
  localparam logic [2:0] ADDR_PERIOD = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  // STATUS register: bit set while a pulse countdown is running
  localparam int STATUS_BUSY_BIT = 0;

  // One-hot decode of a qualified write strobe
  typedef struct packed {
    logic data;
    logic set;
    logic clr;
    logic pulse;
    logic period;
  } wr_dec_t;

endpackage
`default_nettype wire

// File: rtl/nios_system_pio_pulse_timer.sv
`default_nettype none
// ============================================================================
// Module      : nios_system_pio_pulse_timer
// Description : Pulse-period down-counter. A load starts the count at
//               max(load_value, 1); the count then decrements once per clock
//               and the expiry strobe is raised on the edge where it leaves 1.
//               A clear or a reload on the same edge pre-empts expiry.
// Ports       : clk, reset      - clock, async active-high reset
//               load            - start/restart the count
//               load_value      - requested period (0 is treated as 1)
//               clear           - abort the count
//               busy            - count is non-zero
//               expire          - this edge is the expiry edge
// Revision    : 1.0  initial release
// ============================================================================
module nios_system_pio_pulse_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             clear,
  output logic             busy,
  output logic             expire
);

  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_load_val;

  // A zero period still produces a one-cycle pulse
  assign w_load_val = (load_value == '0) ? c_one : load_value;

  assign busy   = (r_cnt != '0);
  assign expire = (r_cnt == c_one) && !load && !clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= w_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - c_one;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nios_system_pio_pulse.sv
`default_nettype none
// ============================================================================
// Module      : nios_system_pio_pulse
// Description : Avalon-MM output PIO with SET/CLR and timed-pulse registers.
//               Pulsed bits are raised immediately and dropped automatically
//               max(PERIOD,1) cycles later unless made steady by SET/CLR.
// Ports       : clk, reset      - clock, async active-high reset
//               address         - register word address (3 bits)
//               chipselect      - slave select
//               write_n         - active-low write strobe
//               writedata       - 32-bit write data
//               readdata        - 32-bit combinational read data
//               out_port        - registered output bits (WIDTH)
// Revision    : 1.0  initial release
// ============================================================================
module nios_system_pio_pulse
  import nios_system_pio_pkg::*;
#(
  parameter int WIDTH         = 2,
  parameter int CNT_W         = 16,
  parameter int DEFAULT_PULSE = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam logic [CNT_W-1:0] c_period_rst = CNT_W'(DEFAULT_PULSE);

  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_pulse_mask;
  logic [CNT_W-1:0] r_period;

  logic [WIDTH-1:0] w_wd;
  wr_dec_t          w_wr;
  logic [WIDTH-1:0] w_data_wr;
  logic [WIDTH-1:0] w_mask_wr;
  logic [WIDTH-1:0] w_data_nxt;
  logic [WIDTH-1:0] w_mask_nxt;
  logic             w_load;
  logic             w_clear;
  logic             w_expire;
  logic             w_busy;
  logic             w_unused_wdata;

  assign w_wd = writedata[WIDTH-1:0];

  // Upper write-data bits are only meaningful for some widths
  assign w_unused_wdata = ^writedata;

  // --------------------------------------------------------------------------
  // Write decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_wr = '0;
    if (chipselect && !write_n) begin
      case (address)
        ADDR_DATA:   w_wr.data   = 1'b1;
        ADDR_SET:    w_wr.set    = 1'b1;
        ADDR_CLR:    w_wr.clr    = 1'b1;
        ADDR_PULSE:  w_wr.pulse  = 1'b1;
        ADDR_PERIOD: w_wr.period = 1'b1;
        default:     ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Effect of the register write alone (before any expiry on this edge)
  // --------------------------------------------------------------------------
  always_comb begin
    w_data_wr = r_data_out;
    w_mask_wr = r_pulse_mask;
    w_load    = 1'b0;
    w_clear   = 1'b0;
    if (w_wr.data) begin
      w_data_wr = w_wd;
      w_mask_wr = '0;
      w_clear   = 1'b1;
    end else if (w_wr.set) begin
      w_data_wr = r_data_out | w_wd;
      w_mask_wr = r_pulse_mask & ~w_wd;
      w_clear   = (w_mask_wr == '0);
    end else if (w_wr.clr) begin
      w_data_wr = r_data_out & ~w_wd;
      w_mask_wr = r_pulse_mask & ~w_wd;
      w_clear   = (w_mask_wr == '0);
    end else if (w_wr.pulse && (w_wd != '0)) begin
      // An all-zero pulse write is a no-op and must not restart the count
      w_data_wr = r_data_out | w_wd;
      w_mask_wr = r_pulse_mask | w_wd;
      w_load    = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Expiry drops only the bits that are still pulsed after the write
  // --------------------------------------------------------------------------
  always_comb begin
    w_data_nxt = w_data_wr;
    w_mask_nxt = w_mask_wr;
    if (w_expire) begin
      w_data_nxt = w_data_wr & ~w_mask_wr;
      w_mask_nxt = '0;
    end
  end

  nios_system_pio_pulse_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (w_load),
    .load_value (r_period),
    .clear      (w_clear),
    .busy       (w_busy),
    .expire     (w_expire)
  );

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_out   <= '0;
      r_pulse_mask <= '0;
      r_period     <= c_period_rst;
    end else begin
      r_data_out   <= w_data_nxt;
      r_pulse_mask <= w_mask_nxt;
      if (w_wr.period) begin
        r_period <= writedata[CNT_W-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read mux (SET, CLR and unused addresses read zero)
  // --------------------------------------------------------------------------
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[WIDTH-1:0]     = r_data_out;
      ADDR_PULSE:  readdata[WIDTH-1:0]     = r_pulse_mask;
      ADDR_PERIOD: readdata[CNT_W-1:0]     = r_period;
      ADDR_STATUS: readdata[STATUS_BUSY_BIT] = w_busy;
      default:     ;
    endcase
  end

  assign out_port = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_nios_system_pio_pulse.sv
`default_nettype none
// ============================================================================
// Module      : tb_nios_system_pio_pulse
// Description : Self-checking bench for nios_system_pio_pulse (WIDTH=4).
//               Directed scenario tasks plus a randomized run against a
//               deadline-based behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_nios_system_pio_pulse;

  localparam int WIDTH         = 4;
  localparam int CNT_W         = 16;
  localparam int DEFAULT_PULSE = 1000;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: pulse expiry tracked as an absolute edge number
  logic [WIDTH-1:0] m_data;
  logic [WIDTH-1:0] m_mask;
  logic [CNT_W-1:0] m_period;
  int               m_deadline;
  int               edge_no = 0;

  nios_system_pio_pulse #(
    .WIDTH         (WIDTH),
    .CNT_W         (CNT_W),
    .DEFAULT_PULSE (DEFAULT_PULSE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    m_data     = '0;
    m_mask     = '0;
    m_period   = CNT_W'(DEFAULT_PULSE);
    m_deadline = 0;
  endtask

  task automatic model_edge(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
    logic [WIDTH-1:0] wd;
    bit pulsed;
    wd     = d[WIDTH-1:0];
    pulsed = 0;
    edge_no++;
    if (reset) begin
      m_reset();
      return;
    end
    if (cs && !wn) begin
      case (a)
        3'd0: begin m_data = wd; m_mask = '0; end
        3'd1: begin m_data = m_data | wd; m_mask = m_mask & ~wd; end
        3'd2: begin m_data = m_data & ~wd; m_mask = m_mask & ~wd; end
        3'd3: if (wd != 0) begin
          m_data     = m_data | wd;
          m_mask     = m_mask | wd;
          m_deadline = edge_no + ((m_period == 0) ? 1 : int'(m_period));
          pulsed     = 1;
        end
        3'd4: m_period = d[CNT_W-1:0];
        default: ;
      endcase
    end
    if (!pulsed && m_mask != 0 && edge_no == m_deadline) begin
      m_data = m_data & ~m_mask;
      m_mask = '0;
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [2:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      3'd0: v[WIDTH-1:0] = m_data;
      3'd3: v[WIDTH-1:0] = m_mask;
      3'd4: v[CNT_W-1:0] = m_period;
      3'd5: v[0] = (m_mask != 0);
      default: ;
    endcase
    return v;
  endfunction

  // One clock: drive at the falling edge, model the rising edge, return at the next falling edge
  task automatic tick(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = d;
    @(posedge clk);
    model_edge(cs, wn, a, d);
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    tick(1'b1, 1'b0, a, d);
  endtask

  task automatic idle();
    tick(1'b0, 1'b1, 3'd0, 32'd0);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    v = readdata;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] exp_rd [8];
    exp_rd = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd1000, 32'd0, 32'd0, 32'd0};
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
    m_reset();
    #1;
    n_tests++; if (out_port !== '0) begin n_fail++; $display("FAIL reset_async: out_port=%h expected=0", out_port); end
    @(negedge clk);
    idle(); idle();
    reset = 1'b0;
    idle();
    n_tests++; if (out_port !== '0) begin n_fail++; $display("FAIL reset_out: out_port=%h expected=0", out_port); end
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), v);
      n_tests++; if (v !== exp_rd[i]) begin n_fail++; $display("FAIL reset_read[%0d]: readdata=%h expected=%h", i, v, exp_rd[i]); end
    end
  endtask

  task automatic test_data_set_clr();
    logic [31:0] v;
    logic [3:0]  exp_o [3];
    logic [2:0]  adr [3];
    logic [3:0]  dat [3];
    exp_o = '{4'h5, 4'h7, 4'h3};
    adr   = '{3'd0, 3'd1, 3'd2};
    dat   = '{4'h5, 4'h2, 4'h4};
    for (int i = 0; i < 3; i++) begin
      wr(adr[i], {28'hABCDEF0, dat[i]});
      n_tests++; if (out_port !== exp_o[i]) begin n_fail++; $display("FAIL data_set_clr[%0d]: out_port=%h expected=%h", i, out_port, exp_o[i]); end
      rd(3'd0, v);
      n_tests++; if (v !== {28'd0, exp_o[i]}) begin n_fail++; $display("FAIL data_readback[%0d]: readdata=%h expected=%h", i, v, exp_o[i]); end
    end
  endtask

  task automatic test_pulse_basic();
    logic [31:0] v;
    wr(3'd0, 32'd0);
    wr(3'd4, 32'd3);
    rd(3'd4, v);
    n_tests++; if (v !== 32'd3) begin n_fail++; $display("FAIL period_read: readdata=%h expected=3", v); end
    wr(3'd3, 32'h1);
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (out_port[0] !== (i < 3)) begin n_fail++; $display("FAIL pulse_basic[%0d]: bit0=%b expected=%b", i, out_port[0], (i < 3)); end
      rd(3'd5, v);
      n_tests++; if (v !== ((i < 3) ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL pulse_status[%0d]: readdata=%h expected=%0d", i, v, (i < 3)); end
      idle();
    end
    rd(3'd3, v);
    n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL pulse_mask_after: readdata=%h expected=0", v); end
  endtask

  task automatic test_back_to_back();
    wr(3'd0, 32'd0);
    wr(3'd4, 32'd5);
    wr(3'd3, 32'h1);
    idle();
    wr(3'd3, 32'h2);
    for (int i = 0; i < 7; i++) begin
      n_tests++; if (out_port !== ((i < 5) ? 4'h3 : 4'h0)) begin n_fail++; $display("FAIL back_to_back[%0d]: out_port=%h expected=%h", i, out_port, (i < 5) ? 4'h3 : 4'h0); end
      idle();
    end
  endtask

  task automatic test_set_on_expiry();
    logic [31:0] v;
    wr(3'd0, 32'd0);
    wr(3'd4, 32'd2);
    wr(3'd3, 32'h3);
    idle();
    wr(3'd1, 32'h1);
    n_tests++; if (out_port !== 4'h1) begin n_fail++; $display("FAIL set_on_expiry: out_port=%h expected=1", out_port); end
    idle();
    n_tests++; if (out_port !== 4'h1) begin n_fail++; $display("FAIL set_steady: out_port=%h expected=1", out_port); end
    rd(3'd5, v);
    n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL set_status: readdata=%h expected=0", v); end
    // zero period behaves as one cycle
    wr(3'd0, 32'd0);
    wr(3'd4, 32'd0);
    wr(3'd3, 32'h1);
    n_tests++; if (out_port !== 4'h1) begin n_fail++; $display("FAIL zero_period_hi: out_port=%h expected=1", out_port); end
    idle();
    n_tests++; if (out_port !== 4'h0) begin n_fail++; $display("FAIL zero_period_lo: out_port=%h expected=0", out_port); end
    // empty pulse write does nothing
    wr(3'd3, 32'h0);
    rd(3'd5, v);
    n_tests++; if (v !== 32'd0 || out_port !== 4'h0) begin n_fail++; $display("FAIL empty_pulse: status=%h out_port=%h expected=0/0", v, out_port); end
  endtask

  task automatic test_reset_mid_pulse();
    logic [31:0] v;
    wr(3'd0, 32'd0);
    wr(3'd4, 32'd10);
    wr(3'd3, 32'h1);
    idle(); idle(); idle();
    #2 reset = 1'b1;
    m_reset();
    #1;
    n_tests++; if (out_port !== 4'h0) begin n_fail++; $display("FAIL reset_mid_async: out_port=%h expected=0", out_port); end
    @(negedge clk);
    idle();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      idle();
      n_tests++; if (out_port !== 4'h0) begin n_fail++; $display("FAIL reset_mid_hold[%0d]: out_port=%h expected=0", i, out_port); end
    end
    rd(3'd5, v);
    n_tests++; if (v !== 32'd0) begin n_fail++; $display("FAIL reset_mid_status: readdata=%h expected=0", v); end
    rd(3'd4, v);
    n_tests++; if (v !== 32'd1000) begin n_fail++; $display("FAIL reset_mid_period: readdata=%h expected=1000", v); end
  endtask

  task automatic test_random();
    logic [31:0] v;
    for (int i = 0; i < 400; i++) begin
      int          op;
      logic        cs, wn;
      logic [2:0]  a;
      logic [31:0] d;
      logic [2:0]  ra;
      op = int'($urandom_range(0, 9));
      d  = $urandom;
      a  = 3'($urandom_range(0, 7));
      cs = 1'b1; wn = 1'b0;
      if (op <= 1) begin cs = 1'b0; wn = 1'($urandom_range(0, 1)); end
      else if (op == 2) begin cs = 1'b1; wn = 1'b1; end
      else if (op >= 7) a = 3'd3;
      if (a == 3'd4) d[15:0] = 16'($urandom_range(0, 6));
      tick(cs, wn, a, d);
      n_tests++; if (out_port !== m_data) begin n_fail++; $display("FAIL rand_out[%0d]: out_port=%h expected=%h", i, out_port, m_data); end
      ra = 3'($urandom_range(0, 7));
      rd(ra, v);
      n_tests++; if (v !== exp_read(ra)) begin n_fail++; $display("FAIL rand_read[%0d] addr=%0d: readdata=%h expected=%h", i, ra, v, exp_read(ra)); end
    end
  endtask

  initial begin
    test_reset();
    test_data_set_clr();
    test_pulse_basic();
    test_back_to_back();
    test_set_on_expiry();
    test_reset_mid_pulse();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
